// File: rtl/addr2coord.sv
// Linear frame-buffer address to (column, row) converter.
// One request at a time through a 20-cycle restoring divider.
module addr2coord #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [19:0] iAddr,
  input  logic        iValid,
  output logic        oReady,
  output logic [12:0] oX,
  output logic [12:0] oY,
  output logic        oErr,
  output logic        oValid,
  input  logic        iReady
);

  localparam logic [14:0] DIVISOR   = 15'(WIDTH);
  localparam logic [20:0] LIMIT     = 21'(WIDTH * HEIGHT);
  localparam logic [4:0]  LAST_ITER = 5'd19;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    DONE
  } state_t;

  state_t      state_reg;
  logic [19:0] dividend_reg;
  logic [13:0] rem_reg;
  logic [12:0] quot_reg;
  logic [4:0]  cnt_reg;
  logic        err_reg;

  logic [14:0] rem_shift;
  logic        q_bit;
  logic [13:0] rem_next;
  logic [12:0] quot_next;
  logic        err_next;
  logic        accept;
  logic        consume;

  // One restoring step: bring in the next dividend bit, subtract when it fits.
  // Only the low 13 quotient bits are kept; higher bits fall off the shift.
  always_comb begin
    rem_shift = {rem_reg, dividend_reg[19]};
    q_bit     = (rem_shift >= DIVISOR);
    rem_next  = q_bit ? 14'(rem_shift - DIVISOR) : rem_shift[13:0];
    quot_next = {quot_reg[11:0], q_bit};
    err_next  = ({1'b0, iAddr} >= LIMIT);
    accept    = iValid && oReady;
    consume   = oValid && iReady;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_reg    <= IDLE;
      dividend_reg <= '0;
      rem_reg      <= '0;
      quot_reg     <= '0;
      cnt_reg      <= '0;
      err_reg      <= 1'b0;
      oReady       <= 1'b1;
      oValid       <= 1'b0;
      oX           <= '0;
      oY           <= '0;
      oErr         <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            dividend_reg <= iAddr;
            rem_reg      <= '0;
            quot_reg     <= '0;
            cnt_reg      <= '0;
            err_reg      <= err_next;
            oReady       <= 1'b0;
            state_reg    <= DIV;
          end
        end

        DIV: begin
          dividend_reg <= dividend_reg << 1;
          rem_reg      <= rem_next;
          quot_reg     <= quot_next;
          cnt_reg      <= cnt_reg + 5'd1;
          // Final step: publish the just-computed result in the same edge.
          if (cnt_reg == LAST_ITER) begin
            oX        <= err_reg ? 13'd0 : rem_next[12:0];
            oY        <= err_reg ? 13'd0 : quot_next;
            oErr      <= err_reg;
            oValid    <= 1'b1;
            state_reg <= DONE;
          end
        end

        DONE: begin
          if (consume) begin
            oValid    <= 1'b0;
            oReady    <= 1'b1;
            state_reg <= IDLE;
          end
        end

        default: begin
          oValid    <= 1'b0;
          oReady    <= 1'b1;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/addr2coord.md
ADDR2COORD -- requirements
Module: addr2coord

Interface
REQ-001 Parameter WIDTH, default 640, pixels per line (divisor); 1 <= WIDTH <= 8191.
REQ-002 Parameter HEIGHT, default 480, lines per frame; WIDTH*HEIGHT <= 2^20.
REQ-003 iCLK  input  1  single clock; all state changes on rising edge.
REQ-004 iRST_N  input  1  reset; asynchronous, active-low.
REQ-005 iAddr  input  20  linear frame-buffer address, captured on accept.
REQ-006 iValid  input  1  request valid; accept occurs when iValid and oReady are both high at a rising edge.
REQ-007 oReady  output  1  block can accept a request.
REQ-008 oX  output  13  column, iAddr mod WIDTH.
REQ-009 oY  output  13  row, iAddr / WIDTH.
REQ-010 oErr  output  1  request was out of range.
REQ-011 oValid  output  1  oX/oY/oErr valid.
REQ-012 iReady  input  1  consumer takes the result when oValid and iReady are both high at a rising edge.

Function
REQ-013 FSM states: IDLE, DIV, DONE; one request in flight at a time, with no pipelining.
REQ-014 oReady SHALL be high only in IDLE; oValid SHALL be high only in DONE.
REQ-015 IDLE->DIV on accept at edge k: latch iAddr, clear the partial remainder, clear the 5-bit iteration counter.
REQ-016 At accept, oErr_next SHALL be computed as (iAddr >= WIDTH*HEIGHT) and latched internally.
REQ-017 DIV: restoring shift-subtract division, one quotient bit per cycle, MSB first.
REQ-018 DIV: each iteration SHALL compute rem = {rem, next dividend bit}; if rem >= WIDTH, subtract WIDTH and set the quotient bit to 1.
REQ-019 DIV->DONE SHALL occur at edge k+20, after the 20th iteration.
REQ-020 At edge k+20, oX SHALL be loaded with the final remainder, oY with the quotient (low 13 bits), and oErr with the latched flag.
REQ-021 The oX, oY and oErr register loads at edge k+20 SHALL be simultaneous.
REQ-022 Latency SHALL be exactly 20 cycles from accept edge to the edge raising oValid, independent of value.
REQ-023 Out-of-range request: oErr=1, oX=0, oY=0, same 20-cycle latency.
REQ-024 DONE: oX, oY, oErr and oValid SHALL hold stable while iReady is low, for any number of cycles.
REQ-025 DONE->IDLE on oValid and iReady at an edge; oValid falls and oReady rises at that same edge.
REQ-026 Minimum issue interval: 22 cycles (accept, 20 DIV cycles, 1 DONE cycle with iReady high).
REQ-027 iValid while not in IDLE SHALL be ignored; iAddr changes during DIV SHALL not affect the result.
REQ-028 Address wrap: iAddr = WIDTH*HEIGHT-1 SHALL yield oX=WIDTH-1, oY=HEIGHT-1; iAddr = WIDTH*HEIGHT SHALL set oErr.
REQ-029 The remainder register SHALL be 14 bits wide so that the comparison never overflows for WIDTH up to 8191.
REQ-030 Round-trip property: for in-range A, oY*WIDTH + oX == A and oX < WIDTH.

Reset
REQ-031 iRST_N low SHALL immediately, without waiting for a clock edge, force state to IDLE.
REQ-032 iRST_N low SHALL immediately clear oX, oY, oErr, oValid, the counter, the remainder and the quotient, and force oReady to 1.
REQ-033 Reset during DIV or DONE SHALL discard the request; no oValid pulse appears after release.
REQ-034 After iRST_N rises, a request SHALL be acceptable on the first rising edge.

Verification
REQ-035 iAddr=645, iReady=1 -> 20 cycles later oValid=1, oX=5, oY=1, oErr=0; iAddr=0 -> (0,0).
REQ-036 iAddr=128200 -> oX=200, oY=200; iAddr=76800 -> oX=0, oY=120.
REQ-037 Boundaries: iAddr=307199 -> oX=639, oY=479, oErr=0; iAddr=307200 and 1048575 -> oErr=1, oX=0, oY=0.
REQ-038 Backpressure: iAddr=645 with iReady low 5 cycles after oValid -> outputs held, oReady=0, and a second iValid during that time is ignored.
REQ-038 (cont.) iReady high -> the held result is consumed at that edge and the next request is accepted at the following edge.
REQ-039 Reset mid-DIV: assert iRST_N low at accept+7 -> outputs cleared asynchronously, oReady=1, no oValid within 30 cycles after release.
REQ-040 Random: 1000 random in-range addresses with random iReady stalls -> REQ-030 holds for every result and latency is always 20 cycles.
